cnt_seq_checker: RTL and testbench

- Receive-side monitor for the free-running wrap counter stream (0..MAX_VAL, then back to 0).
- Locks onto the stream at a 0 sample and checks every valid sample against the expected next value.
- Flags sequence errors and counts wraps.
- Produces a registered "multiple of 3" flag per accepted sample by tracking the residue incrementally, with no divider.

---
 rtl/cnt_chk_pkg.sv | 15 +
 rtl/mod3_tracker.sv | 33 +++
 rtl/cnt_seq_checker.sv | 137 +++++++++++++
 tb/tb_cnt_seq_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared types and constants for the wrap-counter sequence checker.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    StUnlocked,
    StLocked,
    StError
  } state_e;

  typedef logic [1:0] residue_t;

  // Terminal count shared with the transmit-side wrap counter.
  localparam int unsigned DefaultMaxVal = 300;

endpackage

// File: rtl/mod3_tracker.sv
// Incremental mod-3 residue of the expected counter value; avoids any divider.
module mod3_tracker
  import cnt_chk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic clear,
  output logic is_zero
);

  residue_t res_q, res_d, base;

  // clear and advance together restart the residue at 0 and step it once.
  always_comb begin
    base  = clear ? residue_t'(0) : res_q;
    res_d = base;
    if (advance) begin
      res_d = (base == residue_t'(2)) ? residue_t'(0) : base + residue_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign is_zero = (res_q == residue_t'(0));

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side monitor for a 0..MAX_VAL wrap counter: locks on 0, flags gaps,
// counts wraps and reports whether each accepted sample is a multiple of 3.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_VAL    = DefaultMaxVal,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned WRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_val,
  input  logic                  err_clr,
  output logic                  locked,
  output logic                  chk_3,
  output logic                  chk_3_valid,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      exp_val_q, exp_val_d;
  logic                  chk_3_q, chk_3_d;
  logic                  chk_3_valid_q, chk_3_valid_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;

  logic accept, relock, mismatch;
  logic res_adv, res_clr, res_is_zero;

  mod3_tracker u_mod3 (
    .clk     (clk),
    .rst     (rst),
    .advance (res_adv),
    .clear   (res_clr),
    .is_zero (res_is_zero)
  );

  always_comb begin
    state_d       = state_q;
    exp_val_d     = exp_val_q;
    chk_3_d       = chk_3_q;
    chk_3_valid_d = 1'b0;
    err_pulse_d   = 1'b0;
    err_sticky_d  = err_sticky_q;
    err_count_d   = err_count_q;
    wrap_count_d  = wrap_count_q;
    accept        = 1'b0;
    relock        = 1'b0;
    mismatch      = 1'b0;
    res_adv       = 1'b0;
    res_clr       = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StLocked: begin
          if (in_val == exp_val_q) accept = 1'b1;
          else                     mismatch = 1'b1;
        end
        default: begin
          if (in_val == '0) begin
            accept = 1'b1;
            relock = 1'b1;
          end
        end
      endcase
    end

    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end

    // A mismatch in the same cycle as err_clr still counts.
    if (mismatch) begin
      state_d      = StError;
      err_pulse_d  = 1'b1;
      err_sticky_d = 1'b1;
      if (err_count_d != '1) err_count_d = err_count_d + ERR_CNT_W'(1);
    end

    if (accept) begin
      state_d       = StLocked;
      chk_3_valid_d = 1'b1;
      // On (re)lock the residue is treated as 0 regardless of its stored value.
      chk_3_d       = relock | res_is_zero;
      if (in_val == MaxVal) begin
        exp_val_d = '0;
        res_clr   = 1'b1;
        if (wrap_count_q != '1) wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
      end else begin
        exp_val_d = in_val + WIDTH'(1);
        res_adv   = 1'b1;
        res_clr   = relock;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StUnlocked;
      exp_val_q     <= '0;
      chk_3_q       <= 1'b0;
      chk_3_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      wrap_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      exp_val_q     <= exp_val_d;
      chk_3_q       <= chk_3_d;
      chk_3_valid_q <= chk_3_valid_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      wrap_count_q  <= wrap_count_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign chk_3       = chk_3_q;
  assign chk_3_valid = chk_3_valid_q;
  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign wrap_count  = wrap_count_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Scoreboard bench: stimulus queues expected chk_3 values, a monitor pops them
// on chk_3_valid; status outputs are checked directly between phases.
module tb_cnt_seq_checker;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned MAX_VAL    = 300;
  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned WRAP_CNT_W = 16;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic [WIDTH-1:0]      in_val;
  logic                  err_clr;
  logic                  locked;
  logic                  chk_3;
  logic                  chk_3_valid;
  logic                  err_pulse;
  logic                  err_sticky;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  bit mon_exp;

  cnt_seq_checker #(
    .WIDTH      (WIDTH),
    .MAX_VAL    (MAX_VAL),
    .ERR_CNT_W  (ERR_CNT_W),
    .WRAP_CNT_W (WRAP_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_val      (in_val),
    .err_clr     (err_clr),
    .locked      (locked),
    .chk_3       (chk_3),
    .chk_3_valid (chk_3_valid),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .wrap_count  (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one input cycle; queue the expected chk_3 if the sample should be accepted.
  task automatic step(input bit v, input int val, input bit clr, input bit acc, input bit e3);
    @(negedge clk);
    in_valid = v;
    in_val   = WIDTH'(val);
    err_clr  = clr;
    if (acc) exp_q.push_back(e3);
  endtask

  // Idle cycle; afterwards outputs reflect the last driven sample.
  task automatic settle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_3_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_chk_3_valid: got chk_3_valid=1 expected 0 at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("chk_3", int'(chk_3), int'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_val   = '0;
    err_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_locked", int'(locked), 0);
    check("rst_chk_3", int'(chk_3), 0);
    check("rst_chk_3_valid", int'(chk_3_valid), 0);
    check("rst_err_sticky", int'(err_sticky), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_wrap_count", int'(wrap_count), 0);
    rst = 1'b0;

    // Values before the first 0 are ignored.
    step(1'b1, 5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b0, 1'b0);
    settle();
    check("prelock_locked", int'(locked), 0);
    check("prelock_err_pulse", int'(err_pulse), 0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1, 1'b0, 1'b1, 1'b0);
    check("lock_locked", int'(locked), 1);
    step(1'b1, 2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1, 1'b1);
    settle();
    check("lock_err_count", int'(err_count), 0);

    // Remainder of a full lap through MAX_VAL and back to 0.
    for (int v = 4; v <= 300; v++) begin
      if (v == 300) begin
        settle();
        check("pre_wrap_count", int'(wrap_count), 0);
      end
      step(1'b1, v, 1'b0, 1'b1, (v % 3) == 0);
    end
    settle();
    check("wrap_count_1", int'(wrap_count), 1);
    step(1'b1, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1, 1'b0, 1'b1, 1'b0);
    settle();
    check("lap_err_count", int'(err_count), 0);
    check("lap_locked", int'(locked), 1);

    // Gap in the sequence: locked at 10, then 12.
    for (int v = 2; v <= 10; v++) step(1'b1, v, 1'b0, 1'b1, (v % 3) == 0);
    step(1'b1, 12, 1'b0, 1'b0, 1'b0);
    settle();
    check("mm_err_pulse", int'(err_pulse), 1);
    check("mm_err_sticky", int'(err_sticky), 1);
    check("mm_err_count", int'(err_count), 1);
    check("mm_locked", int'(locked), 0);
    step(1'b1, 13, 1'b0, 1'b0, 1'b0);
    check("mm_pulse_one_cycle", int'(err_pulse), 0);
    step(1'b1, 14, 1'b0, 1'b0, 1'b0);
    settle();
    check("err_state_err_count", int'(err_count), 1);
    check("err_state_err_pulse", int'(err_pulse), 0);
    check("err_state_locked", int'(locked), 0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b1);
    settle();
    check("relock_locked", int'(locked), 1);

    // Idle gap while locked at 50, then 51.
    for (int v = 1; v <= 50; v++) step(1'b1, v, 1'b0, 1'b1, (v % 3) == 0);
    repeat (20) settle();
    check("gap_locked", int'(locked), 1);
    step(1'b1, 51, 1'b0, 1'b1, 1'b1);
    settle();
    check("gap_err_count", int'(err_count), 1);
    check("gap_err_pulse", int'(err_pulse), 0);
    check("gap_locked_after", int'(locked), 1);

    // Mismatch coincident with err_clr: the mismatch wins.
    step(1'b1, 99, 1'b1, 1'b0, 1'b0);
    settle();
    check("clr_mm_err_sticky", int'(err_sticky), 1);
    check("clr_mm_err_count", int'(err_count), 1);
    check("clr_mm_locked", int'(locked), 0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    settle();
    check("clr_err_sticky", int'(err_sticky), 0);
    check("clr_err_count", int'(err_count), 0);
    check("clr_locked", int'(locked), 0);
    step(1'b1, 53, 1'b0, 1'b0, 1'b0);
    settle();
    check("clr_no_recount", int'(err_count), 0);

    // Asynchronous reset in the middle of a lap.
    for (int v = 0; v <= 150; v++) step(1'b1, v, 1'b0, 1'b1, (v % 3) == 0);
    settle();
    check("pre_rst_locked", int'(locked), 1);
    check("pre_rst_chk_3", int'(chk_3), 1);
    check("pre_rst_wrap_count", int'(wrap_count), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_chk_3", int'(chk_3), 0);
    check("async_rst_wrap_count", int'(wrap_count), 0);
    check("async_rst_err_sticky", int'(err_sticky), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 151, 1'b0, 1'b0, 1'b0);
    step(1'b1, 152, 1'b0, 1'b0, 1'b0);
    settle();
    check("post_rst_locked", int'(locked), 0);
    check("post_rst_err_count", int'(err_count), 0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b1);
    settle();
    check("post_rst_relock", int'(locked), 1);
    check("post_rst_wrap_count", int'(wrap_count), 0);

    repeat (2) settle();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
